// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares one LSU data port between the core path (r0) and the loader/debug master (r1)
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_rX_req/wren/addr/st_data/lsu_op/ld_un   request and fields of requester X (held until o_rX_gnt)
//   o_rX_gnt                     combinational accept
//   o_rX_rvalid, o_rX_ld_data    response pulse two cycles after accept; load data or 0 for a store
//   o_lsu_addr/st_data/lsu_wren/lsu_op/ld_un   issue register driving the LSU
//   i_ld_data                    LSU load data, combinational in the issue cycle
module lsu_port_arbiter #(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_r0_req,
   input  logic        i_r0_wren,
   input  logic [31:0] i_r0_addr,
   input  logic [31:0] i_r0_st_data,
   input  logic [1:0]  i_r0_lsu_op,
   input  logic        i_r0_ld_un,
   output logic        o_r0_gnt,
   output logic        o_r0_rvalid,
   output logic [31:0] o_r0_ld_data,
   input  logic        i_r1_req,
   input  logic        i_r1_wren,
   input  logic [31:0] i_r1_addr,
   input  logic [31:0] i_r1_st_data,
   input  logic [1:0]  i_r1_lsu_op,
   input  logic        i_r1_ld_un,
   output logic        o_r1_gnt,
   output logic        o_r1_rvalid,
   output logic [31:0] o_r1_ld_data,
   output logic [31:0] o_lsu_addr,
   output logic [31:0] o_st_data,
   output logic        o_lsu_wren,
   output logic [1:0]  o_lsu_op,
   output logic        o_ld_un,
   input  logic [31:0] i_ld_data
);
   logic [CNT_W-1:0] hold_cnt;
   logic             iss_vld, iss_own;
   logic             win1, stall, go;
   logic             sel_wren;
   logic [31:0]      sel_addr;
   always_comb begin
      win1     = i_r1_req && (!i_r0_req || hold_cnt == CNT_W'(HOLD_MAX));
      sel_wren = win1 ? i_r1_wren : i_r0_wren;
      sel_addr = win1 ? i_r1_addr : i_r0_addr;
      // the store in the issue slot commits at the coming edge, so a same-word load must wait a cycle
      stall    = o_lsu_wren && !sel_wren && sel_addr[31:2] == o_lsu_addr[31:2];
      go       = (i_r0_req || i_r1_req) && !stall && !i_reset;
      o_r0_gnt = go && !win1;
      o_r1_gnt = go && win1;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hold_cnt     <= '0;
         iss_vld      <= 1'b0;
         iss_own      <= 1'b0;
         o_lsu_addr   <= '0;
         o_st_data    <= '0;
         o_lsu_wren   <= 1'b0;
         o_lsu_op     <= '0;
         o_ld_un      <= 1'b0;
         o_r0_rvalid  <= 1'b0;
         o_r1_rvalid  <= 1'b0;
         o_r0_ld_data <= '0;
         o_r1_ld_data <= '0;
      end else begin
         hold_cnt    <= (!i_r1_req || o_r1_gnt) ? '0 :
                        (o_r0_gnt && hold_cnt != CNT_W'(HOLD_MAX)) ? hold_cnt + 1'b1 : hold_cnt;
         iss_vld     <= go;
         o_lsu_wren  <= go && sel_wren;
         if (go) begin
            iss_own    <= win1;
            o_lsu_addr <= sel_addr;
            o_st_data  <= win1 ? i_r1_st_data : i_r0_st_data;
            o_lsu_op   <= win1 ? i_r1_lsu_op : i_r0_lsu_op;
            o_ld_un    <= win1 ? i_r1_ld_un : i_r0_ld_un;
         end
         o_r0_rvalid <= iss_vld && !iss_own;
         o_r1_rvalid <= iss_vld && iss_own;
         if (iss_vld && !iss_own) o_r0_ld_data <= o_lsu_wren ? '0 : i_ld_data;
         if (iss_vld && iss_own) o_r1_ld_data <= o_lsu_wren ? '0 : i_ld_data;
      end
   end
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: directed and random checks of lsu_port_arbiter against a transaction-level model
module tb_lsu_port_arbiter;
   localparam int HOLD = 4;
   logic        clk = 1'b0, rst = 1'b1;
   logic        r0_req = 0, r0_wren = 0, r0_un = 0, r1_req = 0, r1_wren = 0, r1_un = 0;
   logic [31:0] r0_addr = 0, r0_st = 0, r1_addr = 0, r1_st = 0;
   logic [1:0]  r0_op = 0, r1_op = 0;
   logic        gnt0, gnt1, rv0, rv1, lsu_wren, ld_un;
   logic [31:0] ld0, ld1, lsu_addr, st_data, ld_data;
   logic [1:0]  lsu_op;
   logic        force_en = 0;
   logic [31:0] force_val = 0;
   logic [31:0] mem [8];
   int          n = 0, fails = 0;
   // reference model state
   int          waits = 0;
   bit          s1_v = 0, s1_own = 0, s1_wr = 0;
   logic [31:0] s1_a = 0, s1_st = 0, s1_d = 0;
   logic [31:0] ref_mem [8];
   bit          exp_rv0 = 0, exp_rv1 = 0;
   logic [31:0] exp_ld0 = 0, exp_ld1 = 0;
   bit          got0 = 0, got1 = 0, act_g0 = 0, act_g1 = 0;

   always #5 clk = ~clk;

   lsu_port_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_r0_req(r0_req), .i_r0_wren(r0_wren), .i_r0_addr(r0_addr), .i_r0_st_data(r0_st),
      .i_r0_lsu_op(r0_op), .i_r0_ld_un(r0_un), .o_r0_gnt(gnt0), .o_r0_rvalid(rv0), .o_r0_ld_data(ld0),
      .i_r1_req(r1_req), .i_r1_wren(r1_wren), .i_r1_addr(r1_addr), .i_r1_st_data(r1_st),
      .i_r1_lsu_op(r1_op), .i_r1_ld_un(r1_un), .o_r1_gnt(gnt1), .o_r1_rvalid(rv1), .o_r1_ld_data(ld1),
      .o_lsu_addr(lsu_addr), .o_st_data(st_data), .o_lsu_wren(lsu_wren), .o_lsu_op(lsu_op),
      .o_ld_un(ld_un), .i_ld_data(ld_data)
   );

   // stand-in LSU: word memory, combinational read, write at the edge after issue
   assign ld_data = force_en ? force_val : mem[lsu_addr[4:2]];
   always @(posedge clk) if (lsu_wren) mem[lsu_addr[4:2]] <= st_data;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req0(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [1:0] op, bit un);
      r0_req = r; r0_wren = w; r0_addr = a; r0_st = d; r0_op = op; r0_un = un;
   endtask

   task automatic req1(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [1:0] op, bit un);
      r1_req = r; r1_wren = w; r1_addr = a; r1_st = d; r1_op = op; r1_un = un;
   endtask

   // one clock: check outputs mid-cycle against the model, then advance the model across the edge
   task automatic cyc();
      bit starved, pick1, wr, g;
      logic [31:0] a;
      @(negedge clk);
      starved = r1_req && r0_req && waits >= HOLD;
      pick1   = r1_req && (!r0_req || starved);
      wr      = pick1 ? r1_wren : r0_wren;
      a       = pick1 ? r1_addr : r0_addr;
      g       = (r0_req || r1_req) && !rst && !(s1_v && s1_wr && !wr && a[31:2] == s1_a[31:2]);
      act_g0  = gnt0;
      act_g1  = gnt1;
      chk("gnt0", gnt0, g && !pick1);
      chk("gnt1", gnt1, g && pick1);
      chk("lsu_wren", lsu_wren, s1_v && s1_wr);
      if (s1_v) chk("lsu_addr", lsu_addr, s1_a);
      if (s1_v && s1_wr) chk("st_data", st_data, s1_st);
      chk("rvalid0", rv0, exp_rv0);
      chk("rvalid1", rv1, exp_rv1);
      chk("ld_data0", ld0, exp_ld0);
      chk("ld_data1", ld1, exp_ld1);
      got0 = g && !pick1;
      got1 = g && pick1;
      if (rst) begin
         waits = 0; s1_v = 0; s1_wr = 0; exp_rv0 = 0; exp_rv1 = 0; exp_ld0 = 0; exp_ld1 = 0;
      end else begin
         exp_rv0 = s1_v && !s1_own;
         exp_rv1 = s1_v && s1_own;
         if (exp_rv0) exp_ld0 = s1_d;
         if (exp_rv1) exp_ld1 = s1_d;
         waits = (!r1_req || got1) ? 0 : got0 ? waits + 1 : waits;
         s1_v = g;
         if (g) begin
            s1_own = pick1; s1_wr = wr; s1_a = a;
            s1_st  = pick1 ? r1_st : r0_st;
            s1_d   = wr ? 32'h0 : force_en ? force_val : ref_mem[a[4:2]];
            if (wr) ref_mem[a[4:2]] = s1_st;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] seq;
      logic [4:0] seq5;
      bit any1;
      for (int i = 0; i < 8; i++) begin mem[i] = 0; ref_mem[i] = 0; end
      // reset held with both requesting
      req0(1, 0, 32'h2004, 0, 0, 0);
      req1(1, 0, 32'h2008, 0, 0, 0);
      @(posedge clk); #1;
      repeat (3) cyc();
      chk("reset_wren", lsu_wren, 0);
      chk("reset_ld0", ld0, 0);
      rst = 0;
      cyc();
      chk("post_reset_r0", act_g0, 1);
      req0(0, 0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      // r1 store then same-word load: one-cycle stall
      req1(1, 1, 32'h2000, 32'h1234, 0, 0);
      cyc();
      chk("sw_gnt", act_g1, 1);
      req1(1, 0, 32'h2000, 0, 0, 0);
      cyc();
      chk("lw_stall", act_g1, 0);
      cyc();
      chk("lw_gnt", act_g1, 1);
      req1(0, 0, 0, 0, 0, 0);
      cyc();
      cyc();
      chk("lw_data", ld1, 32'h1234);
      cyc();
      // starvation guard
      req0(1, 0, 32'h2004, 0, 0, 0);
      req1(1, 0, 32'h2008, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin cyc(); seq[i] = act_g1; end
      chk("starve_seq", {22'h0, seq}, 32'h210);
      req0(0, 0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      // size/sign fields pass through, returned data follows the LSU
      force_en = 1; force_val = 32'hFFFF_FF80;
      req0(1, 0, 32'h1001_0000, 0, 2'b11, 0);
      cyc();
      req0(0, 0, 0, 0, 0, 0);
      chk("lb_op", lsu_op, 2'b11);
      chk("lb_un0", ld_un, 0);
      cyc(); cyc();
      chk("lb_signed", ld0, 32'hFFFF_FF80);
      force_val = 32'h0000_0080;
      req0(1, 0, 32'h1001_0000, 0, 2'b11, 1);
      cyc();
      req0(0, 0, 0, 0, 0, 0);
      chk("lbu_un1", ld_un, 1);
      cyc(); cyc();
      chk("lbu_data", ld0, 32'h0000_0080);
      force_en = 0;
      // reset in the issue cycle drops the response
      req0(1, 0, 32'h200C, 0, 0, 0);
      cyc();
      req0(0, 0, 0, 0, 0, 0);
      rst = 1;
      cyc();
      rst = 0;
      cyc();
      chk("mid_reset_rv", rv0, 0);
      chk("mid_reset_wren", lsu_wren, 0);
      // r1 withdraws while r0 streams
      req0(1, 0, 32'h2010, 0, 0, 0);
      req1(1, 0, 32'h2014, 0, 0, 0);
      any1 = 0;
      repeat (2) begin cyc(); any1 |= act_g1; end
      req1(0, 0, 0, 0, 0, 0);
      repeat (3) begin cyc(); any1 |= act_g1; end
      chk("withdraw_no_gnt", any1, 0);
      req1(1, 0, 32'h2014, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin cyc(); seq5[i] = act_g1; end
      chk("withdraw_cnt_cleared", seq5, 5'b10000);
      req0(0, 0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      // random traffic on a small address window to provoke same-word hazards
      for (int i = 0; i < 600; i++) begin
         if (!r0_req || got0)
            req0($urandom_range(3) != 0, $urandom_range(1), 32'h2000 | ($urandom_range(7) << 2),
                 $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)));
         else if ($urandom_range(31) == 0) r0_req = 0;
         if (!r1_req || got1)
            req1($urandom_range(1) != 0, $urandom_range(1), 32'h2000 | ($urandom_range(7) << 2),
                 $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)));
         else if ($urandom_range(31) == 0) r1_req = 0;
         cyc();
      end
      req0(0, 0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0, 0);
      repeat (4) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule

// File: doc/lsu_port_arbiter.md
Name: lsu_port_arbiter

Overview:
Shares the single LSU data port (address, store data, wren, lsu_op, ld_un, ld_data) between two requesters: r0 = core load/store path, r1 = memory loader/debug master (hex preload, IO poke).
- Req/gnt handshake per requester; fixed priority to r0 with a starvation guard for r1.
- Two-stage pipeline (issue register, response register); throughput one transaction per cycle.
- Sits between requesters and the lsu instance; the LSU's IO map and memory map are unchanged.

Parameters:
HOLD_MAX, 4, max consecutive r0 grants while r1 is waiting before r1 is forced a grant (1..15)
CNT_W, 4, width of the hold counter; must hold HOLD_MAX

Ports:
i_clk  in  1  global clock
i_reset  in  1  synchronous active-high reset
i_r0_req  in  1  r0 request; held high with stable fields until o_r0_gnt
i_r0_wren  in  1  r0 store (1) / load (0)
i_r0_addr  in  32  r0 byte address
i_r0_st_data  in  32  r0 store data
i_r0_lsu_op  in  2  r0 size: 0x word, 10 half, 11 byte
i_r0_ld_un  in  1  r0 unsigned-load flag
o_r0_gnt  out  1  r0 request accepted this cycle (combinational)
o_r0_rvalid  out  1  one-cycle response pulse for r0
o_r0_ld_data  out  32  r0 load result, valid with o_r0_rvalid
i_r1_req, i_r1_wren, i_r1_addr, i_r1_st_data, i_r1_lsu_op, i_r1_ld_un  in  1/1/32/32/2/1  same as r0
o_r1_gnt, o_r1_rvalid, o_r1_ld_data  out  1/1/32  same as r0
o_lsu_addr  out  32  to LSU i_lsu_addr
o_st_data  out  32  to LSU i_st_data
o_lsu_wren  out  1  to LSU i_lsu_wren
o_lsu_op  out  2  to LSU i_lsu_op
o_ld_un  out  1  to LSU i_ld_un
i_ld_data  in  32  from LSU o_ld_data (combinational in issue cycle)

Behaviour:
- Reset, synchronous: all o_* registers 0 (including o_lsu_wren, both rvalid, both ld_data); hold_cnt=0; issue/resp valid=0. In-flight transactions are dropped, so no rvalid after reset. gnt is 0 while i_reset is high.
- Cycle N, accept: at most one gnt per cycle; fields of the granted requester are captured into the issue register.
  - Only r0 requesting: grant r0.
  - Only r1 requesting: grant r1.
  - Both requesting and hold_cnt < HOLD_MAX: grant r0.
  - Both requesting and hold_cnt == HOLD_MAX: grant r1.
- hold_cnt:
  - +1 on an r0 grant while r1 req is high, saturating at HOLD_MAX.
  - Cleared on any r1 grant, or in any cycle r1 req is low.
- Cycle N+1, issue: o_lsu_* driven from the issue register. o_lsu_wren=1 only for a store, as a single-cycle pulse. Issue valid=0 forces o_lsu_wren=0; address and data hold their last value.
- Cycle N+2, response: o_rX_rvalid=1 for the owner of the issue slot.
  - Load: o_rX_ld_data = i_ld_data sampled at end of N+1.
  - Store: o_rX_ld_data = 0 (write ack).
  - The other requester's rvalid stays 0; ld_data holds between responses.
- Back-to-back: accept allowed every cycle; responses return in grant order. A load issued the cycle after a store to the same word must see the stored value. The LSU commits the store at the next posedge after issue, so the arbiter stalls (gnt=0 for one cycle) any load accepted immediately after a store when word addresses (addr[31:2]) match.
- Requester changing fields while req is high and ungranted: no effect until the grant cycle. Req dropping before gnt: request withdrawn, no response.
- Same requester back-to-back: gnt may be high on consecutive cycles; each grant gets exactly one rvalid.

Test Plan:
- Reset: hold i_reset 3 cycles with both req high -> gnt=0, o_lsu_wren=0, all outputs 0. Release -> r0 granted first cycle.
- Single r1 store then load: sw 0x0000_1234 to 0x0000_2000, then lw 0x2000 -> one-cycle stall between them, r1 rvalid pulses at N+2 and N+4, second ld_data=0x0000_1234.
- Starvation guard (HOLD_MAX=4): r0 and r1 req continuously -> grant sequence r0,r0,r0,r0,r1,r0,r0,r0,r0,r1…
- Size and sign passthrough: r0 lb from IO 0x1001_0000 with i_io_sw=0x0000_0080, ld_un=0 -> o_r0_ld_data=0xFFFF_FF80; ld_un=1 -> 0x0000_0080.
- Reset mid-operation: grant r0 load, assert i_reset at N+1 -> no rvalid at N+2, o_lsu_wren=0.
- Withdrawal: r1 req high 2 cycles while r0 is streaming (hold_cnt<4), then r1 drops -> no r1 gnt or rvalid, hold_cnt returns to 0.
